// File: rtl/decode_pkg.sv
// Shared field geometry and the decoded-instruction record for the decode stage.
package decode_pkg;

  localparam int unsigned COND_WIDTH      = 2;
  localparam int unsigned OPCODE_WIDTH    = 4;
  localparam int unsigned REG_ADDR_WIDTH  = 3;
  localparam int unsigned SHIFT_OUT_WIDTH = 5;
  localparam int unsigned TAG_WIDTH       = 4;

  // Raw instruction: cond | opcode | dest | src1 | src2 | spare low bit.
  localparam int unsigned INSTR_WIDTH = COND_WIDTH + OPCODE_WIDTH + 3 * REG_ADDR_WIDTH + 1;

  // Field LSB positions, built up from bit 0.
  localparam int unsigned SRC2_LSB   = 1;
  localparam int unsigned SRC1_LSB   = SRC2_LSB + REG_ADDR_WIDTH;
  localparam int unsigned DEST_LSB   = SRC1_LSB + REG_ADDR_WIDTH;
  localparam int unsigned OPCODE_LSB = DEST_LSB + REG_ADDR_WIDTH;
  localparam int unsigned COND_LSB   = OPCODE_LSB + OPCODE_WIDTH;

  // Shift amount is src2 plus the spare bit below it.
  localparam int unsigned SHIFT_FIELD_WIDTH = REG_ADDR_WIDTH + 1;

  typedef struct packed {
    logic [COND_WIDTH-1:0]      cond;
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [REG_ADDR_WIDTH-1:0]  dest;
    logic [REG_ADDR_WIDTH-1:0]  src1;
    logic [REG_ADDR_WIDTH-1:0]  src2;
    logic [SHIFT_OUT_WIDTH-1:0] shift;
    logic [TAG_WIDTH-1:0]       tag;
  } decoded_t;

endpackage

// File: rtl/decode_field_split.sv
// Pure combinational split of a raw instruction into its decoded fields (tag left zero).
module decode_field_split
  import decode_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] instr,
  output decoded_t               fields
);

  // Slice each field; shift is zero-extended from the low bits.
  always_comb begin
    fields        = '0;
    fields.cond   = instr[COND_LSB +: COND_WIDTH];
    fields.opcode = instr[OPCODE_LSB +: OPCODE_WIDTH];
    fields.dest   = instr[DEST_LSB +: REG_ADDR_WIDTH];
    fields.src1   = instr[SRC1_LSB +: REG_ADDR_WIDTH];
    fields.src2   = instr[SRC2_LSB +: REG_ADDR_WIDTH];
    fields.shift  = SHIFT_OUT_WIDTH'(instr[SHIFT_FIELD_WIDTH-1:0]);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: field split, valid/ready handshake with a one-deep skid entry
// behind the output register, synchronous flush and a wrapping sequence tag.
module decode_stage
  import decode_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COND_WIDTH-1:0]      out_cond,
  output logic [OPCODE_WIDTH-1:0]    out_opcode,
  output logic [REG_ADDR_WIDTH-1:0]  out_dest,
  output logic [REG_ADDR_WIDTH-1:0]  out_src1,
  output logic [REG_ADDR_WIDTH-1:0]  out_src2,
  output logic [SHIFT_OUT_WIDTH-1:0] out_shift,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic [1:0]                 occupancy
);

  decoded_t             split_fields, in_entry;
  decoded_t             main_q, main_d, skid_q, skid_d;
  logic                 main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [1:0]           occupancy_q, occupancy_d;
  logic                 accept, main_free;

  decode_field_split u_split (
    .instr  (in_instr),
    .fields (split_fields)
  );

  // Stamp the incoming entry with the current sequence number.
  always_comb begin
    in_entry     = split_fields;
    in_entry.tag = tag_q;
  end

  // Ready depends only on local state and flush, never on out_ready.
  always_comb begin
    in_ready  = reset_n & ~skid_valid_q & ~flush;
    accept    = in_valid & in_ready;
    main_free = ~main_valid_q | out_ready;
  end

  // Next-state: flush wins; otherwise the skid entry drains into main before new input.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    tag_d        = tag_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (main_free) begin
        if (skid_valid_q) begin
          // in_ready is low here, so no accept can collide with this move.
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d       = in_entry;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
      if (accept) begin
        tag_d = tag_q + 1'b1;
      end
    end
    occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  // State registers; reset clears everything including held entries and the tag counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      tag_q        <= '0;
      occupancy_q  <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      tag_q        <= tag_d;
      occupancy_q  <= occupancy_d;
    end
  end

  // Outputs come straight from the main register.
  always_comb begin
    out_valid  = main_valid_q;
    out_cond   = main_q.cond;
    out_opcode = main_q.opcode;
    out_dest   = main_q.dest;
    out_src1   = main_q.src1;
    out_src2   = main_q.src2;
    out_shift  = main_q.shift;
    out_tag    = main_q.tag;
    occupancy  = occupancy_q;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomised checks for decode_stage at default widths.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [15:0] in_instr;
  logic        in_ready, out_valid;
  logic [1:0]  out_cond;
  logic [3:0]  out_opcode;
  logic [2:0]  out_dest, out_src1, out_src2;
  logic [4:0]  out_shift;
  logic [3:0]  out_tag;
  logic [1:0]  occupancy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cond   (out_cond),
    .out_opcode (out_opcode),
    .out_dest   (out_dest),
    .out_src1   (out_src1),
    .out_src2   (out_src2),
    .out_shift  (out_shift),
    .out_tag    (out_tag),
    .occupancy  (occupancy)
  );

  logic [19:0] dut_fields;
  assign dut_fields = {out_cond, out_opcode, out_dest, out_src1, out_src2, out_shift};

  // Reference decode written directly from the 16-bit field layout.
  function automatic logic [19:0] model(input logic [15:0] i);
    return {i[15:14], i[13:10], i[9:7], i[6:4], i[3:1], 1'b0, i[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  logic [19:0] sb[$];
  logic [19:0] exp_e;
  logic [3:0]  mtag;
  logic        ir0;

  initial begin
    // 1: reset values and single decode of 16'h4EAD
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_tag", out_tag, 0);
    check("rst_fields", dut_fields, 0);
    do_reset();
    check("rst_in_ready", in_ready, 1);
    in_valid = 1'b1; in_instr = 16'h4EAD; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_cond", out_cond, 1);
    check("t1_opcode", out_opcode, 3);
    check("t1_dest", out_dest, 5);
    check("t1_src1", out_src1, 2);
    check("t1_src2", out_src2, 6);
    check("t1_shift", out_shift, 13);
    check("t1_tag", out_tag, 0);
    tick();
    check("t1_drained", out_valid, 0);
    check("t1_occ", occupancy, 0);

    // 2: back-to-back stream
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = 16'h1111 * 16'(i + 1);
      tick();
      check("t2_valid", out_valid, 1);
      check("t2_tag", out_tag, i);
      check("t2_fields", dut_fields, model(16'h1111 * 16'(i + 1)));
      check("t2_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("t2_end_valid", out_valid, 0);

    // 3: backpressure fills main and skid; order kept on release
    do_reset();
    in_valid = 1'b1; in_instr = 16'h1234;
    tick();
    check("t3_occ1", occupancy, 1);
    check("t3_ready1", in_ready, 1);
    in_instr = 16'hABCD;
    tick();
    check("t3_occ2", occupancy, 2);
    check("t3_ready2", in_ready, 0);
    in_instr = 16'h5A5A;
    tick();
    check("t3_hold_occ", occupancy, 2);
    check("t3_hold_tag", out_tag, 0);
    check("t3_hold_fields", dut_fields, model(16'h1234));
    out_ready = 1'b1;
    #1;
    check("t3_ready_indep", in_ready, 0);
    tick();
    check("t3_o1_tag", out_tag, 1);
    check("t3_o1_fields", dut_fields, model(16'hABCD));
    check("t3_o1_occ", occupancy, 1);
    check("t3_o1_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t3_o2_tag", out_tag, 2);
    check("t3_o2_fields", dut_fields, model(16'h5A5A));
    check("t3_o2_occ", occupancy, 1);
    tick();
    check("t3_end_valid", out_valid, 0);
    check("t3_end_occ", occupancy, 0);

    // 4: flush with both entries held; tag counter survives
    do_reset();
    in_valid = 1'b1; in_instr = 16'h0F0F;
    tick();
    in_instr = 16'hF0F0;
    tick();
    check("t4_occ2", occupancy, 2);
    flush = 1'b1; in_instr = 16'h3333;
    #1;
    check("t4_flush_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("t4_flush_valid", out_valid, 0);
    check("t4_flush_occ", occupancy, 0);
    in_instr = 16'h7777; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_post_valid", out_valid, 1);
    check("t4_post_tag", out_tag, 2);
    check("t4_post_fields", dut_fields, model(16'h7777));

    // 5: tag wraps after 16 accepts
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_instr = 16'(i * 977);
      tick();
      check("t5_tag", out_tag, i % 16);
    end
    in_valid = 1'b0;
    tick();

    // 6: asynchronous reset while full
    do_reset();
    in_valid = 1'b1; in_instr = 16'hFFFF;
    tick();
    in_instr = 16'hEEEE;
    tick();
    in_valid = 1'b0;
    check("t6_occ2", occupancy, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_occ", occupancy, 0);
    check("t6_async_fields", dut_fields, 0);
    check("t6_async_tag", out_tag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t6_release_ready", in_ready, 1);

    // Random traffic against a queue scoreboard
    do_reset();
    sb.delete();
    mtag = '0;
    for (int c = 0; c < 400; c++) begin
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = 16'($urandom());
      out_ready = 1'b0;
      #1;
      ir0 = in_ready;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("rnd_ready_indep", in_ready, ir0);
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("rnd_spurious_valid", out_valid, 0);
          end else begin
            exp_e = sb.pop_front();
            check("rnd_tag", out_tag, exp_e[19:16]);
            check("rnd_fields", dut_fields, model(exp_e[15:0]));
          end
        end
        if (in_valid && in_ready) begin
          sb.push_back({mtag, in_instr});
          mtag = mtag + 1'b1;
        end
      end
      tick();
      check("rnd_occ", occupancy, sb.size());
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid && sb.size() != 0) begin
        exp_e = sb.pop_front();
        check("drain_tag", out_tag, exp_e[19:16]);
        check("drain_fields", dut_fields, model(exp_e[15:0]));
      end
      tick();
    end
    check("drain_occ", occupancy, 0);
    check("drain_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
